branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the in-flight prediction queue depth, a power of two from 2 to 8.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port push_valid, input, 1 bit: fetch issued an instruction with a prediction this cycle.
REQ-005 The module SHALL have port push_pc, input, 16 bits: PC of the fetched instruction.
REQ-006 The module SHALL have port push_npc_pred, input, 16 bits: next PC that fetch used.
REQ-007 The module SHALL have port res_valid, input, 1 bit: execute resolved the oldest in-flight instruction.
REQ-008 The module SHALL have port res_pc, input, 16 bits: PC of the resolved instruction.
REQ-009 The module SHALL have port res_npc_actual, input, 16 bits: true next PC.
REQ-010 The module SHALL have port btb_we, output, 1 bit: BTB write enable.
REQ-011 The module SHALL have port btb_pc_actual, output, 16 bits: BTB write PC.
REQ-012 The module SHALL have port btb_npc_actual, output, 16 bits: BTB write target.
REQ-013 The module SHALL have port flush, output, 1 bit: kill younger instructions.
REQ-014 The module SHALL have port redirect_pc, output, 16 bits: fetch restart address, valid while flush=1.
REQ-015 The module SHALL have port full, output, 1 bit: queue full.
REQ-016 The module SHALL have port empty, output, 1 bit: queue empty.
REQ-017 The module SHALL have port count, output, 4 bits: current queue occupancy.
REQ-018 The module SHALL have port mispredict_cnt, output, 16 bits: number of mispredicts.
REQ-019 The module SHALL have port err, output, 1 bit: sticky protocol error.

Function
REQ-020 The queue SHALL be a FIFO of {pc, npc_pred} entries; full=(count==DEPTH), empty=(count==0), both combinational from count.
REQ-021 In state RUN, push_valid with !full SHALL write the entry at the tail on the same edge.
REQ-022 A push while full (and no pop that cycle) SHALL be dropped and SHALL set err.
REQ-023 res_valid with !empty SHALL pop the head on the same edge; a simultaneous push and pop SHALL be accepted even when full, leaving count unchanged.
REQ-024 res_valid while empty SHALL be ignored and SHALL set err.
REQ-025 If res_pc != head.pc on a pop, the module SHALL set err; the compare SHALL still use the head entry.
REQ-026 A mispredict is a pop where head.npc_pred != res_npc_actual.
REQ-027 On the edge after a mispredict, btb_we SHALL be 1 for exactly 1 cycle, with btb_pc_actual=head.pc and btb_npc_actual=res_npc_actual (1-cycle registered latency).
REQ-028 On the edge after a mispredict, flush SHALL be 1 for exactly 1 cycle and redirect_pc SHALL equal res_npc_actual.
REQ-029 On the edge after a mispredict, mispredict_cnt SHALL increment, wrapping from 0xFFFF to 0.
REQ-030 A correct prediction SHALL produce no BTB write and no flush.
REQ-031 The FSM SHALL have two states, RUN and FLUSH: a mispredict pop in RUN goes to FLUSH; FLUSH always returns to RUN on the next edge.
REQ-032 On entering FLUSH, all queue entries SHALL be discarded: count=0 and pointers reset, including any push in the mispredict cycle.
REQ-033 In FLUSH, push_valid and res_valid SHALL be ignored, with no err and no pop.
REQ-034 btb_we, flush and redirect_pc SHALL be registered outputs with no combinational path from inputs.
REQ-035 Pointers SHALL wrap modulo DEPTH.
REQ-036 err SHALL clear only on reset.

Reset
REQ-037 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=RUN, count=0, pointers=0, btb_we=0, flush=0, redirect_pc=0x0000, btb_pc_actual=0x0000, btb_npc_actual=0x0000, mispredict_cnt=0, err=0.
REQ-038 Reset asserted mid-FLUSH or with a pending write SHALL suppress that btb_we/flush pulse.
REQ-039 After rst_n deasserts, the first clock edge SHALL behave as RUN.

Verification
REQ-040 Push {0x0100,0x0104}, then resolve 0x0100/0x0104 -> no btb_we, no flush, count 1->0.
REQ-041 Push {0x0200,0x0204}, then resolve 0x0200/0x0340 -> next cycle btb_we=1, btb_pc_actual=0x0200, btb_npc_actual=0x0340, flush=1, redirect_pc=0x0340, mispredict_cnt=1; one cycle later all pulses low.
REQ-042 Push 3 entries, mispredict the first while pushing a 4th -> count=0 after the edge, the next cycle's push and resolve are ignored, err=0.
REQ-043 Fill to DEPTH=4, push again -> dropped, err=1; then push+resolve in the same cycle while full -> count stays 4.
REQ-044 Resolve while empty -> err=1 and no output pulses; resolve with res_pc mismatching the head -> err=1 and the compare still occurs.
REQ-045 Assert rst_n low between the mispredict edge and the pulse cycle -> btb_we=0 and flush=0 immediately; afterwards count=0 and mispredict_cnt=0.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution unit: tracks in-flight fetch predictions in a FIFO,
// compares each against the resolved next PC, and on a mispredict issues
// a one-cycle BTB update plus a pipeline flush/redirect.
module branch_resolve #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_valid,
    input  logic [15:0] push_pc,
    input  logic [15:0] push_npc_pred,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic [15:0] res_npc_actual,
    output logic        btb_we,
    output logic [15:0] btb_pc_actual,
    output logic [15:0] btb_npc_actual,
    output logic        flush,
    output logic [15:0] redirect_pc,
    output logic        full,
    output logic        empty,
    output logic [3:0]  count,
    output logic [15:0] mispredict_cnt,
    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state;
    logic [15:0]     q_pc  [DEPTH];
    logic [15:0]     q_npc [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [15:0]     head_pc;
    logic [15:0]     head_npc;
    logic            pop_ok;
    logic            push_ok;
    logic            mispredict;
    logic            err_set;

    // Queue status flags and head entry view
    always_comb begin
        full     = (count == 4'(DEPTH));
        empty    = (count == '0);
        head_pc  = q_pc[head_ptr];
        head_npc = q_npc[head_ptr];
    end

    // Accept/reject decisions for this cycle's push and resolve
    always_comb begin
        pop_ok     = (state == RUN) && res_valid && !empty;
        // a pop in the same cycle frees a slot, so a full queue still accepts the push
        push_ok    = (state == RUN) && push_valid && (!full || pop_ok);
        mispredict = pop_ok && (head_npc != res_npc_actual);
        err_set    = (state == RUN) &&
                     ((push_valid && full && !pop_ok) ||
                      (res_valid && empty) ||
                      (pop_ok && (res_pc != head_pc)));
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_pc[tail_ptr]  <= push_pc;
            q_npc[tail_ptr] <= push_npc_pred;
        end
    end

    // Control FSM, queue pointers and registered resolution outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            head_ptr       <= '0;
            tail_ptr       <= '0;
            count          <= '0;
            btb_we         <= 1'b0;
            btb_pc_actual  <= '0;
            btb_npc_actual <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            err            <= 1'b0;
        end else begin
            btb_we <= 1'b0;
            flush  <= 1'b0;
            if (err_set) begin
                err <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (mispredict) begin
                        // flush discards everything, including a push in this same cycle
                        state          <= FLUSH;
                        head_ptr       <= '0;
                        tail_ptr       <= '0;
                        count          <= '0;
                        btb_we         <= 1'b1;
                        btb_pc_actual  <= head_pc;
                        btb_npc_actual <= res_npc_actual;
                        flush          <= 1'b1;
                        redirect_pc    <= res_npc_actual;
                        mispredict_cnt <= mispredict_cnt + 16'd1;
                    end else begin
                        if (push_ok) begin
                            tail_ptr <= tail_ptr + PW'(1);
                        end
                        if (pop_ok) begin
                            head_ptr <= head_ptr + PW'(1);
                        end
                        if (push_ok && !pop_ok) begin
                            count <= count + 4'd1;
                        end else if (pop_ok && !push_ok) begin
                            count <= count - 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: stimulus queues the expected BTB/flush
// pulse for each intended mispredict; a monitor pops and compares on every pulse.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic [15:0] push_pc;
    logic [15:0] push_npc_pred;
    logic        res_valid;
    logic [15:0] res_pc;
    logic [15:0] res_npc_actual;
    logic        btb_we;
    logic [15:0] btb_pc_actual;
    logic [15:0] btb_npc_actual;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic [15:0] mispredict_cnt;
    logic        err;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] npc;
        logic [15:0] cnt;
    } pulse_t;

    pulse_t sb[$];
    int checks   = 0;
    int failures = 0;

    branch_resolve #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_npc_pred  (push_npc_pred),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_npc_actual (res_npc_actual),
        .btb_we         (btb_we),
        .btb_pc_actual  (btb_pc_actual),
        .btb_npc_actual (btb_npc_actual),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .mispredict_cnt (mispredict_cnt),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs return to idle 1 time unit after the edge
    task automatic cyc(input logic pv, input logic [15:0] ppc, input logic [15:0] pnpc,
                       input logic rv, input logic [15:0] rpc, input logic [15:0] rnpc);
        push_valid     = pv;
        push_pc        = ppc;
        push_npc_pred  = pnpc;
        res_valid      = rv;
        res_pc         = rpc;
        res_npc_actual = rnpc;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic expect_pulse(input logic [15:0] pc, input logic [15:0] npc, input logic [15:0] cnt);
        pulse_t p;
        p.pc  = pc;
        p.npc = npc;
        p.cnt = cnt;
        sb.push_back(p);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_btb_we", 32'(btb_we), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mcnt", 32'(mispredict_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (btb_we || flush) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {15'd0, btb_we, 15'd0, flush}, 32'd0);
            end else begin
                pulse_t p;
                p = sb.pop_front();
                chk("pulse_btb_we", 32'(btb_we), 32'd1);
                chk("pulse_flush", 32'(flush), 32'd1);
                chk("pulse_btb_pc", 32'(btb_pc_actual), 32'(p.pc));
                chk("pulse_btb_npc", 32'(btb_npc_actual), 32'(p.npc));
                chk("pulse_redirect", 32'(redirect_pc), 32'(p.npc));
                chk("pulse_mcnt", 32'(mispredict_cnt), 32'(p.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        push_valid     = 1'b0;
        push_pc        = '0;
        push_npc_pred  = '0;
        res_valid      = 1'b0;
        res_pc         = '0;
        res_npc_actual = '0;

        // Reset state before any clock edge
        #2;
        chk("init_count", 32'(count), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_full", 32'(full), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_btb_we", 32'(btb_we), 32'd0);
        chk("init_flush", 32'(flush), 32'd0);
        chk("init_redirect", 32'(redirect_pc), 32'd0);
        chk("init_mcnt", 32'(mispredict_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Correct prediction: no pulses, count 1 -> 0
        cyc(1, 16'h0100, 16'h0104, 0, 0, 0);
        chk("c_count1", 32'(count), 32'd1);
        chk("c_empty0", 32'(empty), 32'd0);
        cyc(0, 0, 0, 1, 16'h0100, 16'h0104);
        chk("c_count0", 32'(count), 32'd0);
        chk("c_empty1", 32'(empty), 32'd1);
        chk("c_err", 32'(err), 32'd0);

        // Mispredict: one pulse, then everything low
        cyc(1, 16'h0200, 16'h0204, 0, 0, 0);
        expect_pulse(16'h0200, 16'h0340, 16'd1);
        cyc(0, 0, 0, 1, 16'h0200, 16'h0340);
        chk("m_count", 32'(count), 32'd0);
        chk("m_mcnt", 32'(mispredict_cnt), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("m_btb_we_low", 32'(btb_we), 32'd0);
        chk("m_flush_low", 32'(flush), 32'd0);

        // Mispredict with a concurrent push; FLUSH ignores the next cycle's traffic
        cyc(1, 16'h0300, 16'h0304, 0, 0, 0);
        cyc(1, 16'h0310, 16'h0314, 0, 0, 0);
        cyc(1, 16'h0320, 16'h0324, 0, 0, 0);
        chk("f_count3", 32'(count), 32'd3);
        expect_pulse(16'h0300, 16'h0400, 16'd2);
        cyc(1, 16'h0330, 16'h0334, 1, 16'h0300, 16'h0400);
        chk("f_count0", 32'(count), 32'd0);
        cyc(1, 16'h0500, 16'h0504, 1, 16'h0500, 16'h0504);
        chk("f_ign_count", 32'(count), 32'd0);
        chk("f_ign_err", 32'(err), 32'd0);
        chk("f_mcnt", 32'(mispredict_cnt), 32'd2);

        // Fill, overflow push, then push+pop while full
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'(16'h0600 + i * 16), 16'(16'h0604 + i * 16), 0, 0, 0);
        end
        chk("o_count4", 32'(count), 32'd4);
        chk("o_full", 32'(full), 32'd1);
        chk("o_err_before", 32'(err), 32'd0);
        cyc(1, 16'h0640, 16'h0644, 0, 0, 0);
        chk("o_drop_count", 32'(count), 32'd4);
        chk("o_err", 32'(err), 32'd1);
        cyc(1, 16'h0650, 16'h0654, 1, 16'h0600, 16'h0604);
        chk("o_pp_count", 32'(count), 32'd4);
        // Drain in order; any wrong ordering would show as an unexpected pulse
        cyc(0, 0, 0, 1, 16'h0610, 16'h0614);
        cyc(0, 0, 0, 1, 16'h0620, 16'h0624);
        cyc(0, 0, 0, 1, 16'h0630, 16'h0634);
        cyc(0, 0, 0, 1, 16'h0650, 16'h0654);
        chk("o_drain_empty", 32'(empty), 32'd1);
        chk("o_mcnt", 32'(mispredict_cnt), 32'd2);

        // Reset between the mispredict edge and the pulse sample suppresses the pulse
        cyc(1, 16'h0700, 16'h0704, 0, 0, 0);
        cyc(0, 0, 0, 1, 16'h0700, 16'h0800);
        do_reset();
        chk("r_count", 32'(count), 32'd0);
        chk("r_mcnt", 32'(mispredict_cnt), 32'd0);

        // Resolve while empty: err, no pulse
        cyc(0, 0, 0, 1, 16'h0800, 16'h0804);
        chk("e_err", 32'(err), 32'd1);
        chk("e_count", 32'(count), 32'd0);
        do_reset();

        // PC mismatch on the head: err, and the compare still produces a mispredict
        cyc(1, 16'h0900, 16'h0904, 0, 0, 0);
        expect_pulse(16'h0900, 16'h0A00, 16'd1);
        cyc(0, 0, 0, 1, 16'h0908, 16'h0A00);
        chk("p_err", 32'(err), 32'd1);
        chk("p_count", 32'(count), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
